// File: rtl/gemm_tile_sequencer.sv
// Purpose : host-side sequencer for the GEMM systolic core; loads weight tiles, streams
//           activation rows with bubble tagging, and buffers real result rows for the host.
// Latency : w handshake -> CMD_WRITE_WEIGHTS 1 cycle; row issue -> out_valid CORE_LAT stream cycles + 1.
// Backpr. : rows are only issued while FIFO occupancy plus real rows in flight is below OUT_DEPTH,
//           so the output FIFO never overflows; bubbles keep the core advancing meanwhile.
// Ports   : clk/resetn; start, cfg_rows, cfg_tiles, busy, done (job control);
//           w_* (weight tile in), act_* (activation row in), out_* (result row out);
//           cmd, weight_inputs, activation_inputs (to core); activation_outputs, output_valid (from core).

typedef enum logic [1:0] {
   CMD_NONE          = 2'd0,
   CMD_WRITE_WEIGHTS = 2'd1,
   CMD_STREAM        = 2'd2
} command_t;

module gemm_tile_sequencer #(
   parameter int SA_SIZE   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_ROWS  = 16,
   parameter int MAX_TILES = 4,
   parameter int CORE_LAT  = 2 * SA_SIZE,
   parameter int OUT_DEPTH = 4
) (
   input  logic                                         clk,
   input  logic                                         resetn,
   input  logic                                         start,
   input  logic [$clog2(MAX_ROWS+1)-1:0]                cfg_rows,
   input  logic [$clog2(MAX_TILES+1)-1:0]               cfg_tiles,
   output logic                                         busy,
   output logic                                         done,
   input  logic                                         w_valid,
   output logic                                         w_ready,
   input  logic [SA_SIZE-1:0][SA_SIZE-1:0][DATA_W-1:0]  w_data,
   input  logic                                         act_valid,
   output logic                                         act_ready,
   input  logic [SA_SIZE-1:0][DATA_W-1:0]               act_data,
   output logic                                         out_valid,
   input  logic                                         out_ready,
   output logic [SA_SIZE-1:0][DATA_W-1:0]               out_data,
   output logic                                         out_last_row,
   output logic                                         out_last,
   output logic [$clog2(MAX_TILES)-1:0]                 out_tile,
   output command_t                                     cmd,
   output logic [SA_SIZE-1:0][SA_SIZE-1:0][DATA_W-1:0]  weight_inputs,
   output logic [SA_SIZE-1:0][DATA_W-1:0]               activation_inputs,
   input  logic [SA_SIZE-1:0][DATA_W-1:0]               activation_outputs,
   input  logic                                         output_valid
);

   localparam int ROW_W  = $clog2(MAX_ROWS+1);
   localparam int TILE_W = $clog2(MAX_TILES+1);
   localparam int TIDX_W = $clog2(MAX_TILES);
   localparam int CNT_W  = $clog2(OUT_DEPTH+1);
   localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

   typedef enum logic [2:0] {S_IDLE, S_WAIT_W, S_LOAD_W, S_STREAM, S_DRAIN, S_WAIT_OUT} state_t;

   typedef struct packed {
      logic [SA_SIZE-1:0][DATA_W-1:0] data;
      logic                           last_row;
      logic                           last;
      logic [TIDX_W-1:0]              tile;
   } out_entry_t;

   state_t              state, state_nxt;
   logic                done_nxt;
   logic [ROW_W-1:0]    rows_q, issued, captured;
   logic [TILE_W-1:0]   tiles_q;
   logic [TIDX_W-1:0]   tile_idx;
   logic [CORE_LAT-1:0] tag;          // 1 = real row at that core pipeline position
   logic                tag_out;
   logic [CNT_W-1:0]    fifo_count;
   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   out_entry_t          fifo_mem [OUT_DEPTH];
   out_entry_t          push_entry, head;
   logic                streaming, credit_ok, issue_real, capture, pop;
   logic                cap_last_row, last_tile, tile_done;

   assign tag_out   = tag[CORE_LAT-1];
   assign streaming = (state == S_STREAM) || (state == S_DRAIN);
   // Captures still in the tag pipe hold a reservation, so a push can never find the FIFO full.
   assign credit_ok  = (int'(fifo_count) + $countones(tag)) < OUT_DEPTH;
   assign issue_real = (state == S_STREAM) && act_valid && credit_ok;
   assign capture    = streaming && tag_out;
   assign pop        = out_valid && out_ready;

   assign cap_last_row = (captured == rows_q - ROW_W'(1));
   assign last_tile    = (TILE_W'(tile_idx) == tiles_q - TILE_W'(1));
   assign tile_done    = (state == S_DRAIN) && ((captured + ROW_W'(capture)) == rows_q);

   assign push_entry = '{data: activation_outputs, last_row: cap_last_row,
                         last: cap_last_row && last_tile, tile: tile_idx};

   assign busy      = (state != S_IDLE);
   assign out_valid = (fifo_count != '0);
   assign head      = out_valid ? fifo_mem[rd_ptr] : '0;
   assign out_data     = head.data;
   assign out_last_row = head.last_row;
   assign out_last     = head.last;
   assign out_tile     = head.tile;

   always_comb begin
      state_nxt         = state;
      done_nxt          = 1'b0;
      cmd               = CMD_NONE;
      w_ready           = 1'b0;
      act_ready         = 1'b0;
      activation_inputs = '0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (cfg_rows == '0 || cfg_tiles == '0) done_nxt  = 1'b1;
               else                                   state_nxt = S_WAIT_W;
            end
         end
         S_WAIT_W: begin
            w_ready = 1'b1;
            if (w_valid) state_nxt = S_LOAD_W;
         end
         S_LOAD_W: begin
            cmd       = CMD_WRITE_WEIGHTS;
            state_nxt = S_STREAM;
         end
         S_STREAM: begin
            cmd = CMD_STREAM;
            if (issue_real) begin
               act_ready         = 1'b1;
               activation_inputs = act_data;
            end
            if ((issued + ROW_W'(issue_real)) == rows_q) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            cmd = CMD_STREAM;
            if (tile_done) state_nxt = last_tile ? S_WAIT_OUT : S_WAIT_W;
         end
         S_WAIT_OUT: begin
            if (fifo_count == '0) begin
               done_nxt  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         done          <= 1'b0;
         rows_q        <= '0;
         tiles_q       <= '0;
         tile_idx      <= '0;
         issued        <= '0;
         captured      <= '0;
         tag           <= '0;
         weight_inputs <= '0;
         fifo_count    <= '0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
         if (state == S_IDLE && state_nxt == S_WAIT_W) begin
            rows_q   <= cfg_rows;
            tiles_q  <= cfg_tiles;
            tile_idx <= '0;
         end
         if (state == S_WAIT_W && w_valid) weight_inputs <= w_data;
         if (state == S_LOAD_W) begin
            issued   <= '0;
            captured <= '0;
         end else begin
            if (issue_real) issued   <= issued + ROW_W'(1);
            if (capture)    captured <= captured + ROW_W'(1);
         end
         if (tile_done && !last_tile) tile_idx <= tile_idx + TIDX_W'(1);
         // The core only moves on stream cycles, so the tags must too.
         if (streaming) tag <= (tag << 1) | CORE_LAT'(issue_real);
         if (capture) wr_ptr <= (wr_ptr == PTR_W'(OUT_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= (rd_ptr == PTR_W'(OUT_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
         case ({capture, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < OUT_DEPTH; i++) fifo_mem[i] <= '0;
      end else if (capture) begin
         fifo_mem[wr_ptr] <= push_entry;
      end
   end

`ifndef SYNTHESIS
   // A tagged slot must carry a real core result.
   tag_implies_valid: assert property (@(posedge clk) disable iff (!resetn) capture |-> output_valid);
`endif

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
module tb_gemm_tile_sequencer;
   localparam int SA = 4, DW = 8, MR = 16, MT = 4, LAT = 8, OD = 2;
   localparam int RW = $clog2(MR+1), TW = $clog2(MT+1), TIW = $clog2(MT);
   localparam logic [1:0] C_NONE = 2'd0, C_WW = 2'd1, C_STREAM = 2'd2;

   logic                          clk = 1'b0, resetn = 1'b0;
   logic                          start = 1'b0;
   logic [RW-1:0]                 cfg_rows = '0;
   logic [TW-1:0]                 cfg_tiles = '0;
   logic                          busy, done;
   logic                          w_valid = 1'b0, w_ready;
   logic [SA-1:0][SA-1:0][DW-1:0] w_data = '0;
   logic                          act_valid = 1'b0, act_ready;
   logic [SA-1:0][DW-1:0]         act_data = '0;
   logic                          out_valid, out_ready = 1'b0;
   logic [SA-1:0][DW-1:0]         out_data;
   logic                          out_last_row, out_last;
   logic [TIW-1:0]                out_tile;
   logic [1:0]                    cmd;
   logic [SA-1:0][SA-1:0][DW-1:0] weight_inputs;
   logic [SA-1:0][DW-1:0]         activation_inputs, activation_outputs;
   logic                          output_valid;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   gemm_tile_sequencer #(.SA_SIZE(SA), .DATA_W(DW), .MAX_ROWS(MR), .MAX_TILES(MT),
                         .CORE_LAT(LAT), .OUT_DEPTH(OD)) dut (
      .clk(clk), .resetn(resetn), .start(start), .cfg_rows(cfg_rows), .cfg_tiles(cfg_tiles),
      .busy(busy), .done(done), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last_row(out_last_row), .out_last(out_last), .out_tile(out_tile),
      .cmd(cmd), .weight_inputs(weight_inputs), .activation_inputs(activation_inputs),
      .activation_outputs(activation_outputs), .output_valid(output_valid));

   // Host-side job data.
   logic [DW-1:0] hw [MT][SA][SA];
   logic [DW-1:0] ha [MT*MR][SA];

   function automatic logic [SA-1:0][DW-1:0] mac(input logic [SA-1:0][DW-1:0] a,
                                                 input logic [SA-1:0][SA-1:0][DW-1:0] w);
      logic [SA-1:0][DW-1:0] r;
      int acc;
      for (int j = 0; j < SA; j++) begin
         acc = 0;
         for (int i = 0; i < SA; i++) acc += int'(a[i]) * int'(w[i][j]);
         r[j] = DW'(acc);
      end
      return r;
   endfunction

   function automatic logic [SA-1:0][SA-1:0][DW-1:0] tile_of(input int t);
      logic [SA-1:0][SA-1:0][DW-1:0] w;
      for (int i = 0; i < SA; i++)
         for (int j = 0; j < SA; j++) w[i][j] = hw[t][i][j];
      return w;
   endfunction

   function automatic logic [SA-1:0][DW-1:0] row_of(input int g);
      logic [SA-1:0][DW-1:0] r;
      for (int i = 0; i < SA; i++) r[i] = ha[g][i];
      return r;
   endfunction

   // Behavioural core: result of the k-th stream row shows up on the (k+LAT)-th stream cycle.
   logic [SA-1:0][DW-1:0]         core_pipe [LAT];
   logic                          core_vld [LAT];
   logic [SA-1:0][SA-1:0][DW-1:0] core_w;
   assign activation_outputs = core_pipe[LAT-1];
   assign output_valid       = core_vld[LAT-1];

   always @(posedge clk) begin
      if (cmd == C_WW) core_w <= weight_inputs;
      if (cmd == C_STREAM) begin
         for (int k = LAT-1; k > 0; k--) begin
            core_pipe[k] <= core_pipe[k-1];
            core_vld[k]  <= core_vld[k-1];
         end
         if (act_valid && act_ready) begin
            core_pipe[0] <= mac(activation_inputs, core_w);
            core_vld[0]  <= 1'b1;
         end else begin
            core_pipe[0] <= $urandom;
            core_vld[0]  <= 1'($urandom_range(0, 1));
         end
      end
   end

   typedef struct {
      logic [SA-1:0][DW-1:0] data;
      logic                  lr;
      logic                  l;
      logic [TIW-1:0]        t;
   } exp_t;
   exp_t exp_q[$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero_outs(input string pfx);
      chk({pfx, "_cmd"}, 64'(cmd), 64'(C_NONE));
      chk({pfx, "_ctl"}, {busy, done, out_valid, w_ready, act_ready}, 0);
      chk({pfx, "_wgt"}, 64'(weight_inputs), 0);
      chk({pfx, "_act"}, 64'(activation_inputs), 0);
      chk({pfx, "_out"}, {out_data, out_last_row, out_last, out_tile}, 0);
   endtask

   task automatic run_job(input int rows, input int tiles, input int act_pct,
                          input int out_pct, input int stall);
      int cyc = 0, wi = 0, ai = 0, got = 0, dones = 0, wws = 0, viol = 0, maxo = 0;
      int total = rows * tiles;
      bit prev_whs = 0, prev_ww = 0, prev_hold = 0, fin = 0;
      logic [63:0] prev_out = '0;
      exp_t e;
      exp_q.delete();
      for (int t = 0; t < tiles; t++)
         for (int r = 0; r < rows; r++) begin
            e.data = mac(row_of(t*rows + r), tile_of(t));
            e.lr   = (r == rows-1);
            e.l    = e.lr && (t == tiles-1);
            e.t    = TIW'(t);
            exp_q.push_back(e);
         end
      @(negedge clk);
      start = 1'b1; cfg_rows = RW'(rows); cfg_tiles = TW'(tiles);
      w_valid = 1'b0; act_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1 chk("busy_after_start", busy, 1);
      while (!fin && cyc < 4000) begin
         @(negedge clk);
         // Starts while busy must be ignored.
         start     = busy && ($urandom_range(0, 9) == 0);
         cfg_rows  = RW'($urandom_range(0, MR));
         cfg_tiles = TW'($urandom_range(0, MT));
         w_valid   = (wi < tiles) && ($urandom_range(0, 99) < 70);
         w_data    = (wi < tiles) ? tile_of(wi) : {$urandom, $urandom};
         if (act_pct < 0) act_valid = (ai < total) && (cyc % 2 == 0);
         else             act_valid = (ai < total) && ($urandom_range(0, 99) < act_pct);
         act_data  = (ai < total) ? row_of(ai) : $urandom;
         out_ready = (cyc >= stall) && ($urandom_range(0, 99) < out_pct);
         #1;
         if (act_ready && cmd != C_STREAM) viol++;
         if (w_ready && cmd != C_NONE) viol++;
         if ((cmd == C_WW) != prev_whs) viol++;
         if (prev_ww && cmd != C_STREAM) viol++;
         if (prev_hold && (!out_valid || 64'({out_data, out_last_row, out_last, out_tile}) != prev_out)) viol++;
         if (cmd == C_WW) wws++;
         if (done) begin dones++; fin = 1; end
         if (w_valid && w_ready) wi++;
         if (act_valid && act_ready) ai++;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("out_extra", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("out_data", 64'(out_data), 64'(e.data));
               chk("out_flags", {out_last_row, out_last, out_tile}, {e.lr, e.l, e.t});
            end
            got++;
         end
         if (ai - got > maxo) maxo = ai - got;
         prev_whs  = w_valid && w_ready;
         prev_ww   = (cmd == C_WW);
         prev_hold = out_valid && !out_ready;
         prev_out  = 64'({out_data, out_last_row, out_last, out_tile});
         cyc++;
      end
      chk("job_finished", fin, 1);
      start = 1'b0; w_valid = 1'b0; act_valid = 1'b0; out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1 if (done) dones++;
      end
      chk("done_count", dones, 1);
      chk("rows_out", got, total);
      chk("exp_left", exp_q.size(), 0);
      chk("ww_count", wws, tiles);
      chk("protocol", viol, 0);
      chk("credit_bound", maxo <= OD, 1);
      chk("busy_idle", busy, 0);
   endtask

   task automatic rand_data();
      for (int t = 0; t < MT; t++)
         for (int i = 0; i < SA; i++)
            for (int j = 0; j < SA; j++) hw[t][i][j] = DW'($urandom_range(1, 255));
      for (int g = 0; g < MT*MR; g++)
         for (int i = 0; i < SA; i++) ha[g][i] = DW'($urandom_range(0, 255));
   endtask

   initial begin
      int n;
      #3 chk_zero_outs("reset");
      #20;
      @(negedge clk) resetn = 1'b1;

      // Identity weights: results equal the input rows.
      for (int i = 0; i < SA; i++)
         for (int j = 0; j < SA; j++) hw[0][i][j] = (i == j) ? 8'd1 : 8'd0;
      for (int g = 0; g < 5; g++)
         for (int i = 0; i < SA; i++) ha[g][i] = DW'((g+1) + 16*i);
      run_job(5, 1, 100, 100, 0);

      // Two tiles: all-ones then 2*I, all-one rows -> 4s then 2s.
      for (int i = 0; i < SA; i++)
         for (int j = 0; j < SA; j++) begin
            hw[0][i][j] = 8'd1;
            hw[1][i][j] = (i == j) ? 8'd2 : 8'd0;
         end
      for (int g = 0; g < 6; g++)
         for (int i = 0; i < SA; i++) ha[g][i] = 8'd1;
      run_job(3, 2, 100, 100, 0);

      // Output stalled for 20 cycles, wide values so sums wrap.
      rand_data();
      run_job(8, 2, 100, 100, 20);

      // Alternating act_valid.
      rand_data();
      run_job(6, 1, -1, 100, 0);

      // Zero-size jobs.
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         start = 1'b1;
         cfg_rows  = (k == 0) ? RW'(0) : RW'(4);
         cfg_tiles = (k == 0) ? TW'(2) : TW'(0);
         @(negedge clk);
         start = 1'b0;
         #1;
         chk("zero_done", done, 1);
         chk("zero_busy", busy, 0);
         chk("zero_cmd", 64'(cmd), 64'(C_NONE));
         @(negedge clk);
         #1 chk("zero_done_pulse", done, 0);
      end

      // Reset during STREAM.
      rand_data();
      @(negedge clk);
      start = 1'b1; cfg_rows = RW'(6); cfg_tiles = TW'(2);
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         w_valid = 1'b1; w_data = tile_of(0);
         act_valid = 1'b1; act_data = row_of(0); out_ready = 1'b0;
         #1;
         if (cmd == C_STREAM && act_ready) break;
         n++;
      end
      chk("reached_stream", n < 200, 1);
      @(negedge clk);
      resetn = 1'b0;
      #1 chk_zero_outs("midreset");
      @(negedge clk);
      w_valid = 1'b0; act_valid = 1'b0;
      @(negedge clk) resetn = 1'b1;
      n = 0;
      repeat (5) begin
         @(negedge clk);
         #1 if (done || busy) n++;
      end
      chk("no_done_after_reset", n, 0);
      run_job(4, 2, 80, 80, 0);

      // Random jobs.
      repeat (5) begin
         rand_data();
         run_job($urandom_range(1, MR), $urandom_range(1, MT),
                 $urandom_range(30, 100), $urandom_range(30, 100), $urandom_range(0, 15));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
